tensor_line_unpacker: RTL and testbench

Upstream feeder for the tensor reordering stage. It accepts DMA_DATA_WIDTH-wide lines of packed COO tensor elements from the DMA read path over a valid/ready handshake. It unpacks each line into TENSOR_WIDTH-wide elements and issues them one at a time on a single-cycle enable strobe. Issue rate is throttled to at most one element per ISSUE_GAP cycles, because the reordering stage has no backpressure and takes 3 cycles per element.

---
 rtl/tensor_line_unpacker.sv | 207 ++++++++++++++++++++
 tb/tb_tensor_line_unpacker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_line_unpacker.sv
// -----------------------------------------------------------------------------
// tensor_line_unpacker
//
// Upstream feeder for the tensor reordering stage. Accepts DMA lines holding N
// packed COO tensor elements over a valid/ready handshake. It then issues the
// elements one at a time, in ascending slot order, on a single-cycle strobe.
// The reordering stage has no backpressure, so consecutive strobes are always
// at least ISSUE_GAP cycles apart.
//
// Parameters
//   TENSOR_WIDTH   width of one packed element
//   DMA_DATA_WIDTH width of one DMA line (integer multiple of TENSOR_WIDTH)
//   ISSUE_GAP      minimum spacing, in cycles, between output strobes (>= 1)
//   COUNT_WIDTH    width of the statistics counters
//
// Ports
//   clk                       clock
//   rst                       synchronous, active-low reset
//   in_line_valid             a DMA line is present on the input
//   in_line_ready             line can be accepted this cycle (= !busy)
//   in_line_data              packed line, element k at [(k+1)*TW-1 : k*TW]
//   in_line_num_valid         valid elements in the line, counted from k=0
//   halt                      suspends element issue while high
//   output_tensor_element_en  one-cycle strobe marking a valid element
//   output_tensor_element     element being issued (holds between strobes)
//   busy                      a line is held in the block
//   elem_count                elements issued since reset (wraps)
//   line_count                lines accepted since reset (wraps)
// -----------------------------------------------------------------------------
module tensor_line_unpacker #(
   parameter int TENSOR_WIDTH   = 128,
   parameter int DMA_DATA_WIDTH = 512,
   parameter int ISSUE_GAP      = 3,
   parameter int COUNT_WIDTH    = 32,
   localparam int N             = DMA_DATA_WIDTH / TENSOR_WIDTH,
   localparam int NV_W          = $clog2(N) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_line_valid,
   output logic                      in_line_ready,
   input  logic [DMA_DATA_WIDTH-1:0] in_line_data,
   input  logic [NV_W-1:0]           in_line_num_valid,
   input  logic                      halt,
   output logic                      output_tensor_element_en,
   output logic [TENSOR_WIDTH-1:0]   output_tensor_element,
   output logic                      busy,
   output logic [COUNT_WIDTH-1:0]    elem_count,
   output logic [COUNT_WIDTH-1:0]    line_count
);

   // Gap counter holds ISSUE_GAP-1 at most; keep at least one bit so the
   // ISSUE_GAP=1 build still has a (constant-zero) counter.
   localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(ISSUE_GAP - 1);
   localparam logic [NV_W-1:0]  NV_MAX     = NV_W'(N);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t                    state_r;
   state_t                    state_nxt_s;

   // Line buffer shifts right by one element per issue, so the element to
   // issue next is always in the lowest slot.
   logic [DMA_DATA_WIDTH-1:0] line_r;
   logic [NV_W-1:0]           nv_r;
   logic [NV_W-1:0]           idx_r;
   logic [GAP_W-1:0]          gap_r;
   logic                      elem_en_r;
   logic [TENSOR_WIDTH-1:0]   elem_r;
   logic [COUNT_WIDTH-1:0]    elem_cnt_r;
   logic [COUNT_WIDTH-1:0]    line_cnt_r;

   logic                      accept_s;
   logic                      issue_s;
   logic                      last_s;
   logic [NV_W-1:0]           nv_clamp_s;

   // Ready is a pure decode of the state register, independent of valid.
   assign busy                     = (state_r == ST_ISSUE);
   assign in_line_ready            = !busy;
   assign output_tensor_element_en = elem_en_r;
   assign output_tensor_element    = elem_r;
   assign elem_count               = elem_cnt_r;
   assign line_count               = line_cnt_r;

   // Next-state, acceptance, issue decision and num_valid clamping.
   always_comb begin
      accept_s    = 1'b0;
      issue_s     = 1'b0;
      last_s      = 1'b0;
      nv_clamp_s  = in_line_num_valid;
      state_nxt_s = state_r;

      if (in_line_num_valid > NV_MAX) begin
         nv_clamp_s = NV_MAX;
      end else begin
         nv_clamp_s = in_line_num_valid;
      end

      accept_s = in_line_valid && (state_r == ST_IDLE);

      case (state_r)
         ST_IDLE: begin
            // An empty line is counted but never enters ISSUE.
            if (accept_s && (nv_clamp_s != {NV_W{1'b0}})) begin
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            issue_s = !halt && (gap_r == {GAP_W{1'b0}}) && (idx_r < nv_r);
            last_s  = issue_s && ((idx_r + NV_W'(1)) == nv_r);
            if (last_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Line buffer, clamped element count and issue index.
   always_ff @(posedge clk) begin
      if (!rst) begin
         line_r <= {DMA_DATA_WIDTH{1'b0}};
         nv_r   <= {NV_W{1'b0}};
         idx_r  <= {NV_W{1'b0}};
      end else if (accept_s) begin
         line_r <= in_line_data;
         nv_r   <= nv_clamp_s;
         idx_r  <= {NV_W{1'b0}};
      end else if (issue_s) begin
         line_r <= line_r >> TENSOR_WIDTH;
         nv_r   <= nv_r;
         idx_r  <= idx_r + NV_W'(1);
      end else begin
         line_r <= line_r;
         nv_r   <= nv_r;
         idx_r  <= idx_r;
      end
   end

   // Gap counter: free-running countdown to zero, reloaded on every issue.
   // It ignores halt and line boundaries so spacing holds across lines.
   always_ff @(posedge clk) begin
      if (!rst) begin
         gap_r <= {GAP_W{1'b0}};
      end else if (issue_s) begin
         gap_r <= GAP_RELOAD;
      end else if (gap_r != {GAP_W{1'b0}}) begin
         gap_r <= gap_r - GAP_W'(1);
      end else begin
         gap_r <= gap_r;
      end
   end

   // Output strobe and element register; element holds between strobes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         elem_en_r <= 1'b0;
         elem_r    <= {TENSOR_WIDTH{1'b0}};
      end else if (issue_s) begin
         elem_en_r <= 1'b1;
         elem_r    <= line_r[TENSOR_WIDTH-1:0];
      end else begin
         elem_en_r <= 1'b0;
         elem_r    <= elem_r;
      end
   end

   // Statistics counters, wrapping modulo 2^COUNT_WIDTH.
   always_ff @(posedge clk) begin
      if (!rst) begin
         elem_cnt_r <= {COUNT_WIDTH{1'b0}};
         line_cnt_r <= {COUNT_WIDTH{1'b0}};
      end else begin
         if (issue_s) begin
            elem_cnt_r <= elem_cnt_r + COUNT_WIDTH'(1);
         end else begin
            elem_cnt_r <= elem_cnt_r;
         end
         if (accept_s) begin
            line_cnt_r <= line_cnt_r + COUNT_WIDTH'(1);
         end else begin
            line_cnt_r <= line_cnt_r;
         end
      end
   end

endmodule

// File: tb/tb_tensor_line_unpacker.sv
module tb_tensor_line_unpacker;
   localparam int TW = 128;
   localparam int DW = 512;
   localparam int NE = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic          v0, h0, ready0, en0, busy0;
   logic [DW-1:0] d0;
   logic [2:0]    n0;
   logic [TW-1:0] el0;
   logic [31:0]   ec0, lc0;

   logic          v1, h1, ready1, en1, busy1;
   logic [DW-1:0] d1;
   logic [2:0]    n1;
   logic [TW-1:0] el1;
   logic [31:0]   ec1, lc1;

   tensor_line_unpacker dut (
      .clk(clk), .rst(rst),
      .in_line_valid(v0), .in_line_ready(ready0), .in_line_data(d0),
      .in_line_num_valid(n0), .halt(h0),
      .output_tensor_element_en(en0), .output_tensor_element(el0),
      .busy(busy0), .elem_count(ec0), .line_count(lc0)
   );

   tensor_line_unpacker #(.ISSUE_GAP(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_line_valid(v1), .in_line_ready(ready1), .in_line_data(d1),
      .in_line_num_valid(n1), .halt(h1),
      .output_tensor_element_en(en1), .output_tensor_element(el1),
      .busy(busy1), .elem_count(ec1), .line_count(lc1)
   );

   // Edge counter: after posedge k, cyc == k.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [TW-1:0] d;
      int            e;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t x0, x1;

   int checks = 0;
   int errors = 0;
   int last0 = -100, last1 = -100;
   int exp_el0 = 0, exp_ln0 = 0, exp_el1 = 0, exp_ln1 = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard monitors: pop and compare on every strobe.
   always @(negedge clk) begin
      if (en0 === 1'b1) begin
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL strobe0_unexpected actual data=%0h edge=%0d required none", el0, cyc);
         end else begin
            x0 = q0.pop_front();
            if (el0 !== x0.d || cyc != x0.e) begin
               errors++;
               $display("FAIL strobe0 actual data=%0h edge=%0d required data=%0h edge=%0d",
                        el0, cyc, x0.d, x0.e);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (en1 === 1'b1) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL strobe1_unexpected actual data=%0h edge=%0d required none", el1, cyc);
         end else begin
            x1 = q1.pop_front();
            if (el1 !== x1.d || cyc != x1.e) begin
               errors++;
               $display("FAIL strobe1 actual data=%0h edge=%0d required data=%0h edge=%0d",
                        el1, cyc, x1.d, x1.e);
            end
         end
      end
   end

   function automatic logic [DW-1:0] make_line(input int base);
      logic [DW-1:0] l;
      l = '0;
      for (int k = 0; k < NE; k++) l[k*TW +: TW] = TW'(base + k);
      return l;
   endfunction

   task automatic wait_edge(input int e);
      while (cyc < e) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents a line and returns the edge at which it was accepted.
   task automatic drive_line(input int sel, input logic [DW-1:0] d, input logic [2:0] n,
                             output int acc);
      logic r;
      acc = -1;
      @(negedge clk);
      if (sel == 0) begin v0 = 1'b1; d0 = d; n0 = n; end
      else          begin v1 = 1'b1; d1 = d; n1 = n; end
      for (int i = 0; i < 200; i++) begin
         r = (sel == 0) ? ready0 : ready1;
         @(posedge clk);
         #1;
         if (r) begin
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (sel == 0) v0 = 1'b0; else v1 = 1'b0;
      if (acc < 0) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=none required=accept sel=%0d", sel);
      end else if (sel == 0) exp_ln0++;
      else exp_ln1++;
   endtask

   // Expected strobes: first at max(accept+1, previous+gap), then every gap.
   task automatic push_line(input int sel, input int base, input int n, input int acc,
                            output int lst);
      int g, e;
      exp_t x;
      g = (sel == 0) ? 3 : 1;
      e = (sel == 0) ? last0 + g : last1 + g;
      if (acc + 1 > e) e = acc + 1;
      lst = e - g;
      for (int k = 0; k < n; k++) begin
         x.d = TW'(base + k);
         x.e = e;
         if (sel == 0) q0.push_back(x); else q1.push_back(x);
         lst = e;
         e = e + g;
      end
      if (sel == 0) begin last0 = lst; exp_el0 += n; end
      else          begin last1 = lst; exp_el1 += n; end
   endtask

   task automatic push_one(input int base, input int e);
      exp_t x;
      x.d = TW'(base);
      x.e = e;
      q0.push_back(x);
   endtask

   task automatic drain(input int sel, input int e);
      wait_edge(e + 6);
      if (sel == 0) begin
         check("q0_drained", 128'(q0.size()), 128'd0);
         check("elem_count0", 128'(ec0), 128'(exp_el0));
         check("line_count0", 128'(lc0), 128'(exp_ln0));
      end else begin
         check("q1_drained", 128'(q1.size()), 128'd0);
         check("elem_count1", 128'(ec1), 128'(exp_el1));
         check("line_count1", 128'(lc1), 128'(exp_ln1));
      end
   endtask

   initial begin
      int a, a2, l;
      rst = 1'b0;
      v0 = 1'b0; h0 = 1'b0; d0 = '0; n0 = 3'd0;
      v1 = 1'b0; h1 = 1'b0; d1 = '0; n1 = 3'd0;
      wait_edge(3);
      check("rst_en", 128'(en0), 128'd0);
      check("rst_elem", 128'(el0), 128'd0);
      check("rst_busy", 128'(busy0), 128'd0);
      check("rst_ready", 128'(ready0), 128'd1);
      check("rst_ec", 128'(ec0), 128'd0);
      check("rst_lc", 128'(lc0), 128'd0);
      @(negedge clk);
      rst = 1'b1;

      // 1: single full line
      drive_line(0, make_line(1), 3'd4, a);
      push_line(0, 1, 4, a, l);
      check("t1_ready_low_after_accept", 128'(ready0), 128'd0);
      wait_edge(l - 1);
      check("t1_ready_low_before_last", 128'(ready0), 128'd0);
      wait_edge(l);
      check("t1_ready_high_after_last", 128'(ready0), 128'd1);
      drain(0, l);

      // 2: two lines with valid held; second first strobe gated by gap counter
      drive_line(0, make_line(32'h10), 3'd4, a);
      push_line(0, 32'h10, 4, a, l);
      drive_line(0, make_line(32'h20), 3'd4, a2);
      check("t2_second_accept_edge", 128'(a2), 128'(a + 11));
      push_line(0, 32'h20, 4, a2, l);
      check("t2_second_first_strobe", 128'(q0[q0.size()-4].e), 128'(a2 + 2));
      drain(0, l);

      // 3: partial, empty and over-range lines
      drive_line(0, make_line(32'h30), 3'd2, a);
      push_line(0, 32'h30, 2, a, l);
      wait_edge(l);
      check("t3_ready_after_partial", 128'(ready0), 128'd1);
      drain(0, l);
      drive_line(0, make_line(32'h40), 3'd0, a);
      check("t3_empty_ready", 128'(ready0), 128'd1);
      check("t3_empty_busy", 128'(busy0), 128'd0);
      drain(0, a);
      drive_line(0, make_line(32'h50), 3'd7, a);
      push_line(0, 32'h50, 4, a, l);
      drain(0, l);

      // 4: halt for 10 edges after first strobe
      drive_line(0, make_line(32'h60), 3'd4, a);
      push_one(32'h60, a + 1);
      wait_edge(a + 1);
      h0 = 1'b1;
      for (int i = 2; i <= 11; i++) begin
         wait_edge(a + i);
         check("t4_ready_low_in_halt", 128'(ready0), 128'd0);
      end
      h0 = 1'b0;
      push_one(32'h61, a + 12);
      push_one(32'h62, a + 15);
      push_one(32'h63, a + 18);
      last0 = a + 18;
      exp_el0 += 4;
      drain(0, a + 18);

      // 5: ISSUE_GAP = 1, back-to-back lines
      drive_line(1, make_line(32'h70), 3'd4, a);
      push_line(1, 32'h70, 4, a, l);
      drive_line(1, make_line(32'h80), 3'd4, a2);
      check("t5_back_to_back_accept", 128'(a2), 128'(a + 5));
      push_line(1, 32'h80, 4, a2, l);
      drain(1, l);
      check("t5_busy1_idle", 128'(busy1), 128'd0);

      // 6: reset after 2nd strobe of a line
      drive_line(0, make_line(32'h90), 3'd4, a);
      push_line(0, 32'h90, 2, a, l);
      wait_edge(l);
      rst = 1'b0;
      wait_edge(l + 1);
      check("t6_rst_en", 128'(en0), 128'd0);
      check("t6_rst_busy", 128'(busy0), 128'd0);
      check("t6_rst_ready", 128'(ready0), 128'd1);
      check("t6_rst_ec", 128'(ec0), 128'd0);
      check("t6_rst_lc", 128'(lc0), 128'd0);
      check("t6_rst_elem", 128'(el0), 128'd0);
      wait_edge(l + 2);
      rst = 1'b1;
      exp_el0 = 0; exp_ln0 = 0; last0 = -100;
      exp_el1 = 0; exp_ln1 = 0; last1 = -100;
      drain(0, l + 14);
      check("t6_busy_after", 128'(busy0), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
